ysyx_22050854_exe_mem_buf: RTL and testbench

YSYX_22050854_EXE_MEM_BUF -- requirements
Module: ysyx_22050854_exe_mem_buf

---
 rtl/ysyx_22050854_exe_mem_buf.sv | 99 +++++++++
 tb/tb_ysyx_22050854_exe_mem_buf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_exe_mem_buf.sv
// ysyx_22050854_exe_mem_buf: two-entry EXE->MEM skid buffer (head, skid) with forwarding of the head entry to ID and an ALU-busy stall counter
module ysyx_22050854_exe_mem_buf #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            exe_valid,
  input  logic            alu_busy,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] exe_pc,
  input  logic [4:0]      exe_rd,
  input  logic            exe_reg_wen,
  input  logic            exe_mem_ren,
  input  logic            exe_mem_wen,
  input  logic [2:0]      exe_mem_size,
  input  logic [XLEN-1:0] exe_store_data,
  output logic            exe_allowin,
  input  logic            mem_allowin,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_res,
  output logic [XLEN-1:0] mem_pc,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_wen,
  output logic            mem_mem_ren,
  output logic            mem_mem_wen,
  output logic [2:0]      mem_mem_size,
  output logic [XLEN-1:0] mem_store_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [2:0]      mem_size;
    logic [XLEN-1:0] store_data;
  } entry_t;
  state_t      state_q, state_d;
  entry_t      head_q, head_d, skid_q, skid_d, in_e, out_e;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        push, pop;
  assign exe_allowin = state_q != TWO;
  assign mem_valid   = state_q != EMPTY;
  assign push        = exe_valid & ~alu_busy & exe_allowin & ~flush;
  assign pop         = mem_valid & mem_allowin;
  assign in_e        = {alu_out, exe_pc, exe_rd, exe_reg_wen, exe_mem_ren, exe_mem_wen, exe_mem_size, exe_store_data};
  assign out_e       = mem_valid ? head_q : '0;
  assign mem_alu_res    = out_e.alu_res;
  assign mem_pc         = out_e.pc;
  assign mem_rd         = out_e.rd;
  assign mem_reg_wen    = out_e.reg_wen;
  assign mem_mem_ren    = out_e.mem_ren;
  assign mem_mem_wen    = out_e.mem_wen;
  assign mem_mem_size   = out_e.mem_size;
  assign mem_store_data = out_e.store_data;
  assign fwd_valid      = mem_valid & out_e.reg_wen & ~out_e.mem_ren & (|out_e.rd);
  assign fwd_rd         = out_e.rd;
  assign fwd_data       = out_e.alu_res;
  assign stall_cnt      = stall_cnt_q;
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q + 32'(exe_valid & alu_busy);
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY && push) begin
      state_d = ONE;
      head_d  = in_e;
    end else if (state_q == ONE && push) begin
      state_d = pop ? ONE : TWO;
      head_d  = pop ? in_e : head_q;
      skid_d  = pop ? skid_q : in_e;
    end else if (state_q == ONE && pop) state_d = EMPTY;
    else if (state_q == TWO && pop) begin
      state_d = ONE;
      head_d  = skid_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_exe_mem_buf.sv
// tb_ysyx_22050854_exe_mem_buf: directed scenarios plus randomized traffic against a queue-based FIFO model
module tb_ysyx_22050854_exe_mem_buf;
  logic        clk = 0, rst = 1, flush = 0, exe_valid = 0, alu_busy = 0, mem_allowin = 0;
  logic [63:0] alu_out = 0, exe_pc = 0, exe_store_data = 0;
  logic [4:0]  exe_rd = 0;
  logic        exe_reg_wen = 0, exe_mem_ren = 0, exe_mem_wen = 0;
  logic [2:0]  exe_mem_size = 0;
  logic        exe_allowin, mem_valid, mem_reg_wen, mem_mem_ren, mem_mem_wen, fwd_valid;
  logic [63:0] mem_alu_res, mem_pc, mem_store_data, fwd_data;
  logic [4:0]  mem_rd, fwd_rd;
  logic [2:0]  mem_mem_size;
  logic [31:0] stall_cnt;
  int n_pass = 0, n_total = 0;
  typedef logic [202:0] ent_t;
  ent_t        mq[$];
  logic [31:0] mstall = 0;
  ent_t        in_vec, out_vec;
  ysyx_22050854_exe_mem_buf #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exe_valid(exe_valid), .alu_busy(alu_busy),
    .alu_out(alu_out), .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_reg_wen(exe_reg_wen),
    .exe_mem_ren(exe_mem_ren), .exe_mem_wen(exe_mem_wen), .exe_mem_size(exe_mem_size),
    .exe_store_data(exe_store_data), .exe_allowin(exe_allowin), .mem_allowin(mem_allowin),
    .mem_valid(mem_valid), .mem_alu_res(mem_alu_res), .mem_pc(mem_pc), .mem_rd(mem_rd),
    .mem_reg_wen(mem_reg_wen), .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen),
    .mem_mem_size(mem_mem_size), .mem_store_data(mem_store_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  assign in_vec  = {alu_out, exe_pc, exe_rd, exe_reg_wen, exe_mem_ren, exe_mem_wen, exe_mem_size, exe_store_data};
  assign out_vec = {mem_alu_res, mem_pc, mem_rd, mem_reg_wen, mem_mem_ren, mem_mem_wen, mem_mem_size, mem_store_data};
  // Capacity-2 FIFO: a pop frees a slot for the push in the same cycle only via replacement of the head
  bit m_pu, m_po;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mstall = 0;
    end else begin
      if (exe_valid && alu_busy) mstall = mstall + 1;
      if (flush) mq.delete();
      else begin
        m_po = mq.size() > 0 && mem_allowin;
        m_pu = exe_valid && !alu_busy && mq.size() < 2;
        if (m_po) void'(mq.pop_front());
        if (m_pu) mq.push_back(in_vec);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    rst = 0; flush = 0; exe_valid = 0; alu_busy = 0; mem_allowin = 0;
    alu_out = 0; exe_pc = 0; exe_rd = 0; exe_reg_wen = 0; exe_mem_ren = 0;
    exe_mem_wen = 0; exe_mem_size = 0; exe_store_data = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 1; exe_valid = 1; alu_out = 64'h77; exe_rd = 3; exe_reg_wen = 1;
    tick();
    n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %0b want 0", mem_valid); else n_pass++;
    n_total++; if (exe_allowin !== 1'b1) $display("FAIL reset_allowin got %0b want 1", exe_allowin); else n_pass++;
    n_total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall got %0d want 0", stall_cnt); else n_pass++;
    n_total++; if (out_vec !== '0 || fwd_valid !== 1'b0 || fwd_data !== 64'd0) $display("FAIL reset_payload got %h fwd %0b want 0", out_vec, fwd_valid); else n_pass++;
    idle();
  endtask
  task automatic test_single();
    idle();
    exe_valid = 1; alu_out = 64'h5; mem_allowin = 1;
    tick();
    n_total++; if (mem_valid !== 1'b1 || mem_alu_res !== 64'h5) $display("FAIL single_out got v=%0b res=%h want v=1 res=5", mem_valid, mem_alu_res); else n_pass++;
    exe_valid = 0;
    tick();
    n_total++; if (mem_valid !== 1'b0 || mem_alu_res !== 64'h0) $display("FAIL single_drain got v=%0b res=%h want v=0 res=0", mem_valid, mem_alu_res); else n_pass++;
  endtask
  task automatic test_back_to_back();
    idle();
    exe_valid = 1; alu_out = 64'h11;
    tick();
    alu_out = 64'h22;
    tick();
    n_total++; if (exe_allowin !== 1'b0 || mem_alu_res !== 64'h11) $display("FAIL b2b_full got allow=%0b res=%h want allow=0 res=11", exe_allowin, mem_alu_res); else n_pass++;
    alu_out = 64'h33;
    tick();
    n_total++; if (exe_allowin !== 1'b0 || mem_alu_res !== 64'h11) $display("FAIL b2b_ignore got allow=%0b res=%h want allow=0 res=11", exe_allowin, mem_alu_res); else n_pass++;
    exe_valid = 0; mem_allowin = 1;
    tick();
    n_total++; if (mem_valid !== 1'b1 || mem_alu_res !== 64'h22 || exe_allowin !== 1'b1) $display("FAIL b2b_second got v=%0b res=%h allow=%0b want v=1 res=22 allow=1", mem_valid, mem_alu_res, exe_allowin); else n_pass++;
    tick();
    n_total++; if (mem_valid !== 1'b0 || mem_alu_res !== 64'h0) $display("FAIL b2b_no_c got v=%0b res=%h want v=0 res=0", mem_valid, mem_alu_res); else n_pass++;
  endtask
  task automatic test_stall();
    idle();
    rst = 1;
    tick();
    rst = 0; exe_valid = 1; alu_busy = 1; alu_out = 64'hDEAD;
    for (int i = 0; i < 33; i++) tick();
    n_total++; if (mem_valid !== 1'b0 || stall_cnt !== 32'd33) $display("FAIL stall_busy got v=%0b cnt=%0d want v=0 cnt=33", mem_valid, stall_cnt); else n_pass++;
    alu_busy = 0; alu_out = 64'hABCD;
    tick();
    n_total++; if (mem_valid !== 1'b1 || mem_alu_res !== 64'hABCD || stall_cnt !== 32'd33) $display("FAIL stall_accept got v=%0b res=%h cnt=%0d want v=1 res=abcd cnt=33", mem_valid, mem_alu_res, stall_cnt); else n_pass++;
    exe_valid = 0; mem_allowin = 1;
    tick();
    n_total++; if (mem_valid !== 1'b0) $display("FAIL stall_single got v=%0b want 0", mem_valid); else n_pass++;
  endtask
  task automatic test_replace();
    idle();
    exe_valid = 1; alu_out = 64'h3;
    tick();
    n_total++; if (mem_alu_res !== 64'h3) $display("FAIL replace_first got %h want 3", mem_alu_res); else n_pass++;
    alu_out = 64'h7; mem_allowin = 1;
    tick();
    n_total++; if (mem_valid !== 1'b1 || mem_alu_res !== 64'h7 || exe_allowin !== 1'b1) $display("FAIL replace_head got v=%0b res=%h allow=%0b want v=1 res=7 allow=1", mem_valid, mem_alu_res, exe_allowin); else n_pass++;
    exe_valid = 0;
    tick();
    n_total++; if (mem_valid !== 1'b0) $display("FAIL replace_drain got v=%0b want 0", mem_valid); else n_pass++;
  endtask
  task automatic test_flush();
    idle();
    exe_valid = 1; alu_out = 64'h1; exe_rd = 4; exe_reg_wen = 1;
    tick();
    alu_out = 64'h2;
    tick();
    n_total++; if (exe_allowin !== 1'b0) $display("FAIL flush_full got allow=%0b want 0", exe_allowin); else n_pass++;
    flush = 1; alu_out = 64'h9; mem_allowin = 1;
    tick();
    n_total++; if (mem_valid !== 1'b0 || exe_allowin !== 1'b1 || fwd_valid !== 1'b0) $display("FAIL flush_empty got v=%0b allow=%0b fwd=%0b want 0 1 0", mem_valid, exe_allowin, fwd_valid); else n_pass++;
    flush = 0; mem_allowin = 0; alu_out = 64'h4;
    tick();
    alu_out = 64'h5;
    tick();
    rst = 1; flush = 1; alu_out = 64'h6;
    tick();
    n_total++; if (mem_valid !== 1'b0 || exe_allowin !== 1'b1 || stall_cnt !== 32'd0) $display("FAIL rst_in_two got v=%0b allow=%0b cnt=%0d want 0 1 0", mem_valid, exe_allowin, stall_cnt); else n_pass++;
    idle();
  endtask
  task automatic test_fwd();
    logic [4:0] rd_t[3]  = '{5'd5, 5'd0, 5'd5};
    logic       ren_t[3] = '{1'b1, 1'b0, 1'b0};
    logic       exp_t[3] = '{1'b0, 1'b0, 1'b1};
    idle();
    mem_allowin = 1; exe_valid = 1; exe_reg_wen = 1;
    for (int i = 0; i < 3; i++) begin
      exe_rd = rd_t[i]; exe_mem_ren = ren_t[i]; alu_out = 64'h100 + 64'(i);
      tick();
      n_total++; if (fwd_valid !== exp_t[i] || fwd_rd !== rd_t[i] || fwd_data !== 64'h100 + 64'(i)) $display("FAIL fwd_case%0d got v=%0b rd=%0d d=%h want v=%0b rd=%0d d=%h", i, fwd_valid, fwd_rd, fwd_data, exp_t[i], rd_t[i], 64'h100 + 64'(i)); else n_pass++;
    end
    idle();
    tick();
  endtask
  task automatic test_random();
    ent_t e;
    logic efv;
    idle();
    rst = 1;
    tick();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      exe_valid = $urandom_range(0, 3) != 0;
      alu_busy = $urandom_range(0, 3) == 0;
      mem_allowin = $urandom_range(0, 1) == 1;
      alu_out = {$urandom, $urandom}; exe_pc = {$urandom, $urandom}; exe_store_data = {$urandom, $urandom};
      exe_rd = 5'($urandom); exe_reg_wen = 1'($urandom); exe_mem_ren = 1'($urandom);
      exe_mem_wen = 1'($urandom); exe_mem_size = 3'($urandom);
      tick();
      e = mq.size() > 0 ? mq[0] : '0;
      efv = mq.size() > 0 && e[69] && !e[68] && e[74:70] != 5'd0;
      n_total++; if (mem_valid !== (mq.size() > 0) || exe_allowin !== (mq.size() < 2)) $display("FAIL rnd_state cyc%0d got v=%0b allow=%0b want size=%0d", c, mem_valid, exe_allowin, mq.size()); else n_pass++;
      n_total++; if (out_vec !== e) $display("FAIL rnd_payload cyc%0d got %h want %h", c, out_vec, e); else n_pass++;
      n_total++; if (fwd_valid !== efv || fwd_rd !== e[74:70] || fwd_data !== e[202:139]) $display("FAIL rnd_fwd cyc%0d got v=%0b rd=%0d want v=%0b rd=%0d", c, fwd_valid, fwd_rd, efv, e[74:70]); else n_pass++;
      n_total++; if (stall_cnt !== mstall) $display("FAIL rnd_stall cyc%0d got %0d want %0d", c, stall_cnt, mstall); else n_pass++;
    end
    idle();
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_replace();
    test_flush();
    test_fwd();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
